mem_arbiter_rr: RTL and testbench
=================================

Name: mem_arbiter_rr

Overview:
- Parametrised N-channel arbiter that merges several CPU-side magic-memory style ports onto one physical memory port.
- Successor to the fixed two-port instruction/data memory arrangement. Channel count, address width and data width are parameters.
- Requests are serialised through a registered request/response FSM with round-robin fairness.
- Sits between the mp3 core (instr and data ports, later the L1 caches) and a single-port memory.

Parameters:
- NUM_CH, 2, number of requesting channels (2..8).
- ADDR_WIDTH, 16, address width in bits.
- DATA_WIDTH, 16, data width in bits; must be a multiple of 8.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- ch_read  in  NUM_CH  per-channel read request, held until ch_resp.
- ch_write  in  NUM_CH  per-channel write request, held until ch_resp.
- ch_byte_enable  in  NUM_CH*(DATA_WIDTH/8)  per-channel write byte mask.
- ch_address  in  NUM_CH*ADDR_WIDTH  per-channel address.
- ch_wdata  in  NUM_CH*DATA_WIDTH  per-channel write data.
- ch_resp  out  NUM_CH  one-cycle completion pulse, one-hot or zero.
- ch_rdata  out  DATA_WIDTH  read data, shared by all channels; valid when any ch_resp bit is set.
- pmem_read  out  1  memory read strobe.
- pmem_write  out  1  memory write strobe.
- pmem_byte_enable  out  DATA_WIDTH/8  memory byte mask.
- pmem_address  out  ADDR_WIDTH  memory address.
- pmem_wdata  out  DATA_WIDTH  memory write data.
- pmem_resp  in  1  memory completion.
- pmem_rdata  in  DATA_WIDTH  memory read data.

Behaviour:
- FSM states: IDLE, BUSY, RESP.
- Reset values:
  - state=IDLE, rr pointer=0 (channel 0 is highest priority first).
  - All pmem_* outputs 0, ch_resp 0, ch_rdata 0, grant register 0.
- IDLE:
  - A channel is requesting when ch_read[i] or ch_write[i] is set.
  - If any channel requests, pick the first requester scanning from rr upward, wrapping at NUM_CH-1 to 0.
  - On the same edge, latch grant, op, address, wdata and byte_enable; go to BUSY.
  - If ch_read and ch_write are both set on one channel, treat it as a write.
- BUSY:
  - pmem_read or pmem_write (exactly one) is driven from the latched registers; the other pmem_* outputs are also driven from the latched copy.
  - Later changes on channel inputs are ignored.
  - On pmem_resp=1: latch pmem_rdata (reads only; writes leave ch_rdata unchanged), drop the strobe on the next cycle, set rr=grant+1 mod NUM_CH, go to RESP.
- RESP: ch_resp[grant]=1 for exactly one cycle with ch_rdata valid, then go to IDLE.
  - RESP exists so the requester can deassert before the next arbitration.
- Latency:
  - Request seen in IDLE at cycle 0; strobe high from cycle 1.
  - pmem_resp at cycle k gives ch_resp at cycle k+1.
  - Minimum 3 cycles request-to-resp (k=1 gives ch_resp at cycle 2) plus one IDLE cycle before the next grant.
- pmem strobes are never asserted in IDLE or RESP. pmem_resp outside BUSY is ignored.
- A channel that drops its request while in BUSY still receives its ch_resp; the transaction is not cancelled.
- Reset mid-transaction:
  - Abandon the transaction; all outputs are 0 from the cycle after the reset edge.
  - No ch_resp is issued for the abandoned transaction.
  - A late pmem_resp is ignored.
- NUM_CH=1 degenerates to a registered pass-through; rr stays 0.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIORITY_EN.
- Defined: rr pointer removed; IDLE always grants the lowest-index requester. Channel 0 can starve the others; this is intended for data-over-instruction priority experiments.
- Undefined: round-robin as described above.
- Both builds keep identical ports and latency.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, BUSY, RESP};
  - localparam helper CH_IDX_W = $clog2(NUM_CH) computed per instance;
  - function rr_pick(req, ptr), returning index and valid.
- One sub-module, rr_pick_comb: a combinational wrap-around priority picker with NUM_CH parameter.
  - It is reused by the future cache-level arbiter and is bypassed when MEM_ARB_FIXED_PRIORITY_EN is defined.

Test Plan:
- Single read: ch_read=2'b01, ch_address[0]=16'h0040, pmem answers 16'hBEEF after 2 BUSY cycles.
  - Expect pmem_address=16'h0040, then ch_resp=2'b01, ch_rdata=16'hBEEF exactly one cycle, then IDLE.
- Masked write: ch1 write addr 16'h1002, wdata 16'hA5A5, be=2'b10.
  - Expect pmem_write=1, pmem_byte_enable=2'b10, ch_resp=2'b10 after pmem_resp.
- Contention: both channels request continuously for 4 transactions.
  - Grant order 0,1,0,1 (round-robin build).
  - With MEM_ARB_FIXED_PRIORITY_EN defined, grant order is 0,0,0,0.
- Input change in BUSY: ch0 changes address from 16'h0010 to 16'h0020 mid-BUSY.
  - Expect pmem_address stays 16'h0010 until pmem_resp.
- Reset mid-op: assert reset during BUSY, then pulse pmem_resp.
  - Expect pmem_read=0 the next cycle, no ch_resp, and rr=0.
- NUM_CH=4: requests on channels 1 and 3 with rr=2.
  - Channel 3 is granted first, then channel 1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the round-robin memory arbiter.
// Channel counts of 1..8 are supported; the picker pads requests to MAX_CH bits.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;

    localparam int MAX_CH = 8;

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Returns {valid, index}: first set request scanning from ptr upward, wrapping at n-1.
    function automatic logic [3:0] rr_pick(input logic [MAX_CH-1:0] req,
                                           input logic [2:0]        ptr,
                                           input int                n);
        logic [3:0] res;
        int         idx;
        res = '0;
        for (int k = MAX_CH - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = (int'(ptr) + k) % n;
                if (req[idx]) res = {1'b1, 3'(idx)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// Channel-side and memory-side bus of the N-channel memory arbiter.
interface mem_arbiter_rr_if #(
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    localparam int BE_W = DATA_WIDTH / 8;

    logic [NUM_CH-1:0]            ch_read;
    logic [NUM_CH-1:0]            ch_write;
    logic [NUM_CH*BE_W-1:0]       ch_byte_enable;
    logic [NUM_CH*ADDR_WIDTH-1:0] ch_address;
    logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata;
    logic [NUM_CH-1:0]            ch_resp;
    logic [DATA_WIDTH-1:0]        ch_rdata;

    logic                         pmem_read;
    logic                         pmem_write;
    logic [BE_W-1:0]              pmem_byte_enable;
    logic [ADDR_WIDTH-1:0]        pmem_address;
    logic [DATA_WIDTH-1:0]        pmem_wdata;
    logic                         pmem_resp;
    logic [DATA_WIDTH-1:0]        pmem_rdata;

    modport slave (
        input  ch_read, ch_write, ch_byte_enable, ch_address, ch_wdata,
        input  pmem_resp, pmem_rdata,
        output ch_resp, ch_rdata,
        output pmem_read, pmem_write, pmem_byte_enable, pmem_address, pmem_wdata
    );

    modport master (
        output ch_read, ch_write, ch_byte_enable, ch_address, ch_wdata,
        output pmem_resp, pmem_rdata,
        input  ch_resp, ch_rdata,
        input  pmem_read, pmem_write, pmem_byte_enable, pmem_address, pmem_wdata
    );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick_comb: combinational wrap-around priority picker, shared with the cache-level arbiter.
module rr_pick_comb
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int CH_IDX_W = ch_idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0]   req,
    input  logic [CH_IDX_W-1:0] ptr,
    output logic [CH_IDX_W-1:0] idx,
    output logic                valid
);
    logic [MAX_CH-1:0] req_pad;
    logic [2:0]        ptr_pad;
    logic [3:0]        pick;

    assign req_pad = MAX_CH'(req);
    assign ptr_pad = 3'(ptr);
    assign pick    = rr_pick(req_pad, ptr_pad, NUM_CH);
    assign valid   = pick[3];
    assign idx     = CH_IDX_W'(pick[2:0]);

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-channel round-robin arbiter onto one single-port memory (IDLE/BUSY/RESP).
// Define MEM_ARB_FIXED_PRIORITY_EN to replace round-robin with lowest-index-wins.
module mem_arbiter_rr
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    mem_arbiter_rr_if.slave  bus
);
    localparam int BE_W     = DATA_WIDTH / 8;
    localparam int CH_IDX_W = ch_idx_w(NUM_CH);

    arb_state_t              state, state_nxt;
    logic [NUM_CH-1:0]       req;
    logic [CH_IDX_W-1:0]     pick_idx;
    logic                    pick_vld;

    logic [CH_IDX_W-1:0]     grant_p1;
    logic                    wr_p1;
    logic [ADDR_WIDTH-1:0]   addr_p1;
    logic [DATA_WIDTH-1:0]   wdata_p1;
    logic [BE_W-1:0]         be_p1;
    logic [DATA_WIDTH-1:0]   rdata_p1;

    assign req = bus.ch_read | bus.ch_write;

`ifdef MEM_ARB_FIXED_PRIORITY_EN
    always_comb begin
        pick_idx = '0;
        pick_vld = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick_idx = CH_IDX_W'(i);
                pick_vld = 1'b1;
            end
        end
    end
`else
    logic [CH_IDX_W-1:0] rr_p1;

    rr_pick_comb #(
        .NUM_CH   (NUM_CH),
        .CH_IDX_W (CH_IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (rr_p1),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    // Pointer advances only on completion, so an abandoned transaction leaves fairness untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_p1 <= '0;
        end else if (state == BUSY && bus.pmem_resp) begin
            if (grant_p1 == CH_IDX_W'(NUM_CH - 1)) rr_p1 <= '0;
            else                                   rr_p1 <= grant_p1 + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        bus.ch_resp     = '0;
        bus.pmem_read   = 1'b0;
        bus.pmem_write  = 1'b0;
        unique case (state)
            IDLE: if (pick_vld) state_nxt = BUSY;
            BUSY: begin
                bus.pmem_read  = ~wr_p1;
                bus.pmem_write = wr_p1;
                if (bus.pmem_resp) state_nxt = RESP;
            end
            RESP: begin
                bus.ch_resp[grant_p1] = 1'b1;
                state_nxt             = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage 1: request captured at grant; channel inputs are ignored until the next IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_p1 <= '0;
            wr_p1    <= 1'b0;
            addr_p1  <= '0;
            wdata_p1 <= '0;
            be_p1    <= '0;
            rdata_p1 <= '0;
        end else begin
            if (state == IDLE && pick_vld) begin
                grant_p1 <= pick_idx;
                wr_p1    <= bus.ch_write[pick_idx];
                addr_p1  <= bus.ch_address[int'(pick_idx) * ADDR_WIDTH +: ADDR_WIDTH];
                wdata_p1 <= bus.ch_wdata[int'(pick_idx) * DATA_WIDTH +: DATA_WIDTH];
                be_p1    <= bus.ch_byte_enable[int'(pick_idx) * BE_W +: BE_W];
            end
            if (state == BUSY && bus.pmem_resp && !wr_p1) rdata_p1 <= bus.pmem_rdata;
        end
    end

    assign bus.pmem_address     = addr_p1;
    assign bus.pmem_wdata       = wdata_p1;
    assign bus.pmem_byte_enable = be_p1;
    assign bus.ch_rdata         = rdata_p1;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: vector table on a 2-channel instance plus hand sequences.
module tb_mem_arbiter_rr;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_rr_if #(.NUM_CH(2), .ADDR_WIDTH(16), .DATA_WIDTH(16)) b2 ();
    mem_arbiter_rr_if #(.NUM_CH(4), .ADDR_WIDTH(16), .DATA_WIDTH(16)) b4 ();

    mem_arbiter_rr #(.NUM_CH(2), .ADDR_WIDTH(16), .DATA_WIDTH(16)) u_dut2 (
        .clk(clk), .reset(reset), .bus(b2));
    mem_arbiter_rr #(.NUM_CH(4), .ADDR_WIDTH(16), .DATA_WIDTH(16)) u_dut4 (
        .clk(clk), .reset(reset), .bus(b4));

    typedef struct {
        bit          rd;
        bit          wr;
        int          ch;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] mem_rdata;
        int          wait_cyc;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[4];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int n, input vec_t v);
        logic [1:0] oh;
        oh = 2'b01 << v.ch;
        b2.ch_read        = v.rd ? oh : 2'b00;
        b2.ch_write       = v.wr ? oh : 2'b00;
        b2.ch_address     = '0;
        b2.ch_wdata       = '0;
        b2.ch_byte_enable = '0;
        b2.ch_address[v.ch*16 +: 16]   = v.addr;
        b2.ch_wdata[v.ch*16 +: 16]     = v.wdata;
        b2.ch_byte_enable[v.ch*2 +: 2] = v.be;
        tick();
        chk($sformatf("v%0d_pmem_read", n),  b2.pmem_read,  v.rd && !v.wr);
        chk($sformatf("v%0d_pmem_write", n), b2.pmem_write, v.wr);
        chk($sformatf("v%0d_pmem_addr", n),  b2.pmem_address, v.addr);
        chk($sformatf("v%0d_pmem_be", n),    b2.pmem_byte_enable, v.be);
        if (v.wr) chk($sformatf("v%0d_pmem_wdata", n), b2.pmem_wdata, v.wdata);
        for (int i = 0; i < v.wait_cyc; i++) begin
            tick();
            chk($sformatf("v%0d_strobe_hold", n), b2.pmem_read | b2.pmem_write, 1);
            chk($sformatf("v%0d_no_early_resp", n), b2.ch_resp, 0);
        end
        b2.pmem_rdata = v.mem_rdata;
        b2.pmem_resp  = 1'b1;
        tick();
        b2.pmem_resp  = 1'b0;
        b2.pmem_rdata = '0;
        chk($sformatf("v%0d_ch_resp", n),  b2.ch_resp, oh);
        chk($sformatf("v%0d_ch_rdata", n), b2.ch_rdata, v.exp_rdata);
        chk($sformatf("v%0d_strobe_drop", n), {b2.pmem_read, b2.pmem_write}, 0);
        b2.ch_read  = '0;
        b2.ch_write = '0;
        tick();
        chk($sformatf("v%0d_resp_one_cycle", n), b2.ch_resp, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ord[4];
        int          first4, second4;
        logic [3:0]  oh4;

`ifdef MEM_ARB_FIXED_PRIORITY_EN
        ord     = '{0, 0, 0, 0};
        first4  = 1;
        second4 = 3;
`else
        ord     = '{0, 1, 0, 1};
        first4  = 3;
        second4 = 1;
`endif
        //            rd    wr    ch addr      wdata     be     mem_rdata wait exp_rdata
        vecs[0] = '{1'b1, 1'b0, 0, 16'h0040, 16'h0000, 2'b11, 16'hBEEF, 2, 16'hBEEF};
        vecs[1] = '{1'b0, 1'b1, 1, 16'h1002, 16'hA5A5, 2'b10, 16'h1234, 1, 16'hBEEF};
        vecs[2] = '{1'b1, 1'b1, 0, 16'h0300, 16'h5A5A, 2'b01, 16'h7777, 0, 16'hBEEF};
        vecs[3] = '{1'b1, 1'b0, 1, 16'hFFFE, 16'h0000, 2'b11, 16'h0001, 3, 16'h0001};

        reset = 1'b1;
        b2.ch_read = '0; b2.ch_write = '0; b2.ch_address = '0; b2.ch_wdata = '0;
        b2.ch_byte_enable = '0; b2.pmem_resp = 1'b0; b2.pmem_rdata = '0;
        b4.ch_read = '0; b4.ch_write = '0; b4.ch_address = '0; b4.ch_wdata = '0;
        b4.ch_byte_enable = '0; b4.pmem_resp = 1'b0; b4.pmem_rdata = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_pmem_read",  b2.pmem_read, 0);
        chk("rst_pmem_write", b2.pmem_write, 0);
        chk("rst_pmem_addr",  b2.pmem_address, 0);
        chk("rst_ch_resp",    b2.ch_resp, 0);
        chk("rst_ch_rdata",   b2.ch_rdata, 0);
        b2.pmem_resp = 1'b1;
        tick();
        b2.pmem_resp = 1'b0;
        chk("idle_ignores_pmem_resp", b2.ch_resp, 0);
        chk("idle_no_strobe", {b2.pmem_read, b2.pmem_write}, 0);

        for (int i = 0; i < 4; i++) run_vec(i, vecs[i]);

        // Address change and request drop during BUSY must not disturb the transaction.
        b2.ch_read    = 2'b01;
        b2.ch_address = {16'h0000, 16'h0010};
        tick();
        chk("chg_addr_start", b2.pmem_address, 16'h0010);
        b2.ch_address = {16'h0000, 16'h0020};
        b2.ch_read    = 2'b00;
        tick();
        chk("chg_addr_hold1", b2.pmem_address, 16'h0010);
        chk("chg_read_hold",  b2.pmem_read, 1);
        tick();
        chk("chg_addr_hold2", b2.pmem_address, 16'h0010);
        b2.pmem_rdata = 16'h2222;
        b2.pmem_resp  = 1'b1;
        tick();
        b2.pmem_resp  = 1'b0;
        chk("chg_ch_resp",  b2.ch_resp, 2'b01);
        chk("chg_ch_rdata", b2.ch_rdata, 16'h2222);
        tick();
        chk("chg_resp_clear", b2.ch_resp, 0);

        // Reset during BUSY on channel 1, then a late pmem_resp.
        b2.ch_read    = 2'b10;
        b2.ch_address = {16'h0050, 16'h0000};
        tick();
        chk("rmid_busy_read", b2.pmem_read, 1);
        chk("rmid_busy_addr", b2.pmem_address, 16'h0050);
        reset      = 1'b1;
        b2.ch_read = 2'b00;
        tick();
        reset = 1'b0;
        chk("rmid_read_low", b2.pmem_read, 0);
        chk("rmid_addr_low", b2.pmem_address, 0);
        chk("rmid_rdata_low", b2.ch_rdata, 0);
        chk("rmid_no_resp", b2.ch_resp, 0);
        b2.pmem_rdata = 16'h9999;
        b2.pmem_resp  = 1'b1;
        tick();
        b2.pmem_resp  = 1'b0;
        chk("rmid_late_resp_ignored", b2.ch_resp, 0);
        chk("rmid_late_rdata_ignored", b2.ch_rdata, 0);
        tick();
        chk("rmid_still_quiet", b2.ch_resp, 0);

        // Continuous contention; the first grant also shows the pointer was reset.
        b2.ch_read    = 2'b11;
        b2.ch_address = {16'h0200, 16'h0100};
        for (int t = 0; t < 4; t++) begin
            tick();
            chk($sformatf("cont%0d_addr", t), b2.pmem_address, ord[t] == 1 ? 16'h0200 : 16'h0100);
            b2.pmem_rdata = 16'hC000 + 16'(t);
            b2.pmem_resp  = 1'b1;
            tick();
            b2.pmem_resp  = 1'b0;
            chk($sformatf("cont%0d_resp", t), b2.ch_resp, 2'b01 << ord[t]);
            chk($sformatf("cont%0d_rdata", t), b2.ch_rdata, 16'hC000 + 16'(t));
            tick();
            chk($sformatf("cont%0d_resp_clear", t), b2.ch_resp, 0);
        end
        b2.ch_read = 2'b00;

        // 4 channels: one transaction on ch1 moves the pointer to 2, then ch1 and ch3 compete.
        b4.ch_address = {16'h0033, 16'h0000, 16'h0011, 16'h0000};
        b4.ch_read    = 4'b0010;
        tick();
        chk("ch4_setup_addr", b4.pmem_address, 16'h0011);
        b4.pmem_rdata = 16'hAAAA;
        b4.pmem_resp  = 1'b1;
        tick();
        b4.pmem_resp  = 1'b0;
        chk("ch4_setup_resp", b4.ch_resp, 4'b0010);
        b4.ch_read = 4'b0000;
        tick();
        b4.ch_read = 4'b1010;
        tick();
        chk("ch4_first_addr", b4.pmem_address, first4 == 3 ? 16'h0033 : 16'h0011);
        b4.pmem_rdata = 16'hBBBB;
        b4.pmem_resp  = 1'b1;
        tick();
        b4.pmem_resp  = 1'b0;
        oh4 = 4'b0001 << first4;
        chk("ch4_first_resp",  b4.ch_resp, oh4);
        chk("ch4_first_rdata", b4.ch_rdata, 16'hBBBB);
        b4.ch_read = b4.ch_read & ~oh4;
        tick();
        tick();
        chk("ch4_second_addr", b4.pmem_address, second4 == 3 ? 16'h0033 : 16'h0011);
        b4.pmem_rdata = 16'hCCCC;
        b4.pmem_resp  = 1'b1;
        tick();
        b4.pmem_resp  = 1'b0;
        chk("ch4_second_resp",  b4.ch_resp, 4'b0001 << second4);
        chk("ch4_second_rdata", b4.ch_rdata, 16'hCCCC);
        b4.ch_read = 4'b0000;
        tick();
        chk("ch4_resp_clear", b4.ch_resp, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
